// File: rtl/mac_cluster_seq.sv
// Job sequencer for a quad MAC cluster. It loads the initial values via the cluster reset,
// streams N gated operand beats, flushes with zeros, then presents the outputs on a valid/ready port.
module mac_cluster_seq #(
   parameter int MIN_W     = 8,
   parameter int ACC_W     = 32,
   parameter int CONF_W    = 4,
   parameter int LEN_W     = 8,
   parameter int DRAIN_CYC = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      job_valid,
   output logic                      job_ready,
   input  logic [4*ACC_W+CONF_W-1:0] job_cfg,
   input  logic [LEN_W-1:0]          job_len,
   input  logic                      op_valid,
   output logic                      op_ready,
   input  logic [4*MIN_W-1:0]        op_a,
   input  logic [4*MIN_W-1:0]        op_b,
   output logic                      clu_rst,
   output logic                      clu_en,
   output logic [4*ACC_W+CONF_W-1:0] clu_cfg,
   output logic [4*MIN_W-1:0]        clu_a,
   output logic [4*MIN_W-1:0]        clu_b,
   input  logic [4*ACC_W-1:0]        clu_out,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [4*ACC_W-1:0]        res_data,
   output logic                      busy
);

   localparam int CFG_W = 4*ACC_W+CONF_W;
   localparam int DC_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, RESULT} state_t;

   state_t             state, state_nxt;
   logic               clu_rst_nxt, clu_en_nxt, res_valid_nxt;
   logic [CFG_W-1:0]   clu_cfg_nxt;
   logic [4*MIN_W-1:0] clu_a_nxt, clu_b_nxt;
   logic [4*ACC_W-1:0] res_data_nxt;
   logic [LEN_W-1:0]   cnt, cnt_nxt;
   logic [DC_W-1:0]    dcnt, dcnt_nxt;
   logic               beat;

   assign job_ready = (state == IDLE) & ~rst;
   assign op_ready  = (state == RUN);
   assign busy      = (state != IDLE);
   assign beat      = op_valid & op_ready;

   // Every registered output is recomputed here; the cluster reset and enable default low.
   always_comb begin
      state_nxt     = state;
      clu_rst_nxt   = 1'b0;
      clu_en_nxt    = 1'b0;
      clu_cfg_nxt   = clu_cfg;
      clu_a_nxt     = clu_a;
      clu_b_nxt     = clu_b;
      cnt_nxt       = cnt;
      dcnt_nxt      = dcnt;
      res_valid_nxt = res_valid;
      res_data_nxt  = res_data;
      case (state)
         IDLE: begin
            if (job_valid && job_ready) begin
               clu_cfg_nxt = job_cfg;
               cnt_nxt     = job_len;
               clu_rst_nxt = 1'b1;
               state_nxt   = LOAD;
            end
         end
         LOAD: begin
            dcnt_nxt  = '0;
            state_nxt = (cnt != '0) ? RUN : DRAIN;
         end
         RUN: begin
            if (beat) begin
               clu_en_nxt = 1'b1;
               clu_a_nxt  = op_a;
               clu_b_nxt  = op_b;
               cnt_nxt    = cnt - LEN_W'(1);
               if (cnt == LEN_W'(1)) begin
                  dcnt_nxt  = '0;
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Zero operands push the last product through without disturbing the sums.
            clu_a_nxt = '0;
            clu_b_nxt = '0;
            if (dcnt == DC_W'(DRAIN_CYC-1)) begin
               res_data_nxt  = clu_out;
               res_valid_nxt = 1'b1;
               state_nxt     = RESULT;
            end else begin
               clu_en_nxt = 1'b1;
               dcnt_nxt   = dcnt + DC_W'(1);
            end
         end
         RESULT: begin
            if (res_ready) begin
               res_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset holds the cluster in reset and drops any pending result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         clu_rst   <= 1'b1;
         clu_en    <= 1'b0;
         clu_cfg   <= '0;
         clu_a     <= '0;
         clu_b     <= '0;
         cnt       <= '0;
         dcnt      <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         state     <= state_nxt;
         clu_rst   <= clu_rst_nxt;
         clu_en    <= clu_en_nxt;
         clu_cfg   <= clu_cfg_nxt;
         clu_a     <= clu_a_nxt;
         clu_b     <= clu_b_nxt;
         cnt       <= cnt_nxt;
         dcnt      <= dcnt_nxt;
         res_valid <= res_valid_nxt;
         res_data  <= res_data_nxt;
      end
   end

endmodule

// File: tb/tb_mac_cluster_seq.sv
// Testbench for mac_cluster_seq with a behavioural quad-MAC cluster stub and a sum-of-products
// reference model; cfg word layout is {init3, init2, init1, init0, mode}.
module tb_mac_cluster_seq;

   localparam int MIN_W     = 8;
   localparam int ACC_W     = 32;
   localparam int CONF_W    = 4;
   localparam int LEN_W     = 4;
   localparam int DRAIN_CYC = 4;
   localparam int CFG_W     = 4*ACC_W+CONF_W;

   logic               clk = 1'b0;
   logic               rst;
   logic               job_valid, job_ready;
   logic [CFG_W-1:0]   job_cfg;
   logic [LEN_W-1:0]   job_len;
   logic               op_valid, op_ready;
   logic [4*MIN_W-1:0] op_a, op_b;
   logic               clu_rst, clu_en;
   logic [CFG_W-1:0]   clu_cfg;
   logic [4*MIN_W-1:0] clu_a, clu_b;
   logic [4*ACC_W-1:0] clu_out;
   logic               res_valid, res_ready;
   logic [4*ACC_W-1:0] res_data;
   logic               busy;

   int checks = 0;
   int errors = 0;
   int op_hs  = 0;

   logic [31:0]  beat_a[$];
   logic [31:0]  beat_b[$];
   logic [31:0]  stub_out[4];
   logic [31:0]  stub_prod[4];

   mac_cluster_seq #(
      .MIN_W(MIN_W), .ACC_W(ACC_W), .CONF_W(CONF_W), .LEN_W(LEN_W), .DRAIN_CYC(DRAIN_CYC)
   ) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_cfg(job_cfg), .job_len(job_len),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .clu_rst(clu_rst), .clu_en(clu_en), .clu_cfg(clu_cfg), .clu_a(clu_a), .clu_b(clu_b),
      .clu_out(clu_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Cluster stub: reset loads the init values, each enabled edge retires the previous product.
   always @(posedge clk) begin
      if (clu_rst) begin
         for (int l = 0; l < 4; l++) begin
            stub_out[l]  <= clu_cfg[CONF_W+32*l +: 32];
            stub_prod[l] <= 32'd0;
         end
      end else if (clu_en) begin
         for (int l = 0; l < 4; l++) begin
            stub_out[l]  <= stub_out[l] + stub_prod[l];
            stub_prod[l] <= 32'(clu_a[8*l +: 8]) * 32'(clu_b[8*l +: 8]);
         end
      end
   end
   assign clu_out = {stub_out[3], stub_out[2], stub_out[1], stub_out[0]};

   always @(posedge clk) begin
      if (op_valid && op_ready) op_hs <= op_hs + 1;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [CFG_W-1:0] obs, input logic [CFG_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit skip_slot(input int stall, input int idx);
      logic [5:0] pat;
      pat = 6'b101001;
      if (stall == 1) return !pat[idx % 6];
      if (stall == 2) return ($urandom_range(0, 2) == 0);
      return 1'b0;
   endfunction

   task automatic start_job(input logic [CFG_W-1:0] cfg, input int n);
      int guard;
      job_cfg   = cfg;
      job_len   = LEN_W'(n);
      job_valid = 1'b1;
      guard     = 0;
      while (!job_ready && guard < 20) begin
         tick();
         guard++;
      end
      check_output("job_ready_wait", job_ready, 1);
      tick();
      job_valid = 1'b0;
      job_cfg   = CFG_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
      check_output("load_clu_rst", clu_rst, 1);
      check_output("load_op_ready", op_ready, 0);
      check_output("load_clu_cfg", clu_cfg, cfg);
      tick();
      check_output("post_load_clu_rst", clu_rst, 0);
   endtask

   task automatic apply_stimulus(input int n, input int stall);
      int idx;
      idx = 0;
      for (int k = 0; k < n; k++) begin
         while (skip_slot(stall, idx)) begin
            op_valid = 1'b0;
            op_a     = $urandom;
            op_b     = $urandom;
            tick();
            idx++;
            check_output("gap_clu_en", clu_en, 0);
         end
         op_valid = 1'b1;
         op_a     = beat_a[k];
         op_b     = beat_b[k];
         tick();
         idx++;
         check_output("beat_clu_en", clu_en, 1);
         check_output("beat_clu_a", clu_a, beat_a[k]);
         check_output("beat_clu_b", clu_b, beat_b[k]);
      end
      op_valid = 1'b0;
   endtask

   // Full job: accept, stream, drain, result with optional backpressure; expectation is init + sum of lane products.
   task automatic run_job(input logic [127:0] inits, input int n, input int stall, input int hold);
      logic [CFG_W-1:0] cfg;
      logic [31:0]      acc[4];
      logic [127:0]     exp_res;
      int               hs_before;
      cfg = {inits, 4'h5};
      for (int l = 0; l < 4; l++) begin
         acc[l] = inits[32*l +: 32];
         for (int k = 0; k < n; k++)
            acc[l] = acc[l] + 32'(beat_a[k][8*l +: 8]) * 32'(beat_b[k][8*l +: 8]);
      end
      exp_res   = {acc[3], acc[2], acc[1], acc[0]};
      hs_before = op_hs;
      start_job(cfg, n);
      if (n > 0) begin
         check_output("run_op_ready", op_ready, 1);
         apply_stimulus(n, stall);
         check_output("drain_op_ready", op_ready, 0);
         for (int d = 1; d < DRAIN_CYC; d++) begin
            tick();
            check_output("drain_clu_en", clu_en, 1);
            check_output("drain_clu_a", clu_a, 0);
            check_output("drain_res_valid", res_valid, 0);
         end
      end else begin
         for (int d = 1; d < DRAIN_CYC; d++) begin
            check_output("zero_op_ready", op_ready, 0);
            check_output("zero_res_valid", res_valid, 0);
            tick();
         end
      end
      tick();
      check_output("res_valid_rise", res_valid, 1);
      check_output("res_clu_en_off", clu_en, 0);
      check_output("res_data", res_data, exp_res);
      res_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         tick();
         check_output("hold_res_valid", res_valid, 1);
         check_output("hold_res_data", res_data, exp_res);
         check_output("hold_job_ready", job_ready, 0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check_output("res_valid_fall", res_valid, 0);
      check_output("idle_busy", busy, 0);
      check_output("idle_clu_cfg", clu_cfg, cfg);
      check_output("op_handshakes", op_hs - hs_before, n);
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      job_valid = 1'b0;
      job_cfg   = '0;
      job_len   = '0;
      op_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      res_ready = 1'b0;
      #23;
      check_output("rst_clu_rst", clu_rst, 1);
      check_output("rst_clu_en", clu_en, 0);
      check_output("rst_res_valid", res_valid, 0);
      check_output("rst_res_data", res_data, 0);
      check_output("rst_clu_a", clu_a, 0);
      check_output("rst_clu_cfg", clu_cfg, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_job_ready", job_ready, 0);
      tick();
      rst = 1'b0;
      tick();
      check_output("release_clu_rst", clu_rst, 0);
      check_output("release_job_ready", job_ready, 1);

      $display("[TB] basic run");
      beat_a = {32'h01010101, 32'h01010102, 32'h01010103};
      beat_b = {32'h01010104, 32'h01010105, 32'h01010106};
      run_job(128'd0, 3, 0, 0);
      run_job({32'd0, 32'd0, 32'd0, 32'd10}, 3, 0, 0);

      $display("[TB] operand stalls and result backpressure");
      run_job(128'd0, 3, 1, 5);

      $display("[TB] zero length");
      run_job({32'd10, 32'd9, 32'd8, 32'd7}, 0, 0, 1);

      $display("[TB] reset mid-run");
      beat_a = {32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 32'h05050505};
      beat_b = beat_a;
      start_job(128'd0, 5);
      apply_stimulus(2, 0);
      rst = 1'b1;
      #1;
      check_output("midrst_busy", busy, 0);
      check_output("midrst_clu_rst", clu_rst, 1);
      check_output("midrst_clu_en", clu_en, 0);
      check_output("midrst_res_valid", res_valid, 0);
      check_output("midrst_op_ready", op_ready, 0);
      tick();
      rst = 1'b0;
      tick();
      beat_a = {32'h00000002};
      beat_b = {32'h00000002};
      run_job(128'd0, 1, 0, 0);

      $display("[TB] maximum length");
      beat_a.delete();
      beat_b.delete();
      for (int k = 0; k < 15; k++) begin
         beat_a.push_back(32'h01010101);
         beat_b.push_back(32'h01010101);
      end
      run_job(128'd0, 15, 0, 0);

      $display("[TB] randomized jobs");
      for (int j = 0; j < 8; j++) begin
         n = $urandom_range(0, 15);
         beat_a.delete();
         beat_b.delete();
         for (int k = 0; k < n; k++) begin
            beat_a.push_back($urandom);
            beat_b.push_back($urandom);
         end
         run_job({$urandom, $urandom, $urandom, $urandom}, n, 2, $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_cluster_seq.md
Name: mac_cluster_seq

Overview:
- Job sequencer in front of one quad MAC cluster.
- Accepts a job (cluster config plus beat count), pulses the cluster reset to load the initial accumulator values, and streams N operand beats into the cluster with `en` gated per beat.
- Flushes the cluster pipeline with zero operands, then snapshots the four outputs into a valid/ready result port.
- Sits between the fabric-side operand/job streams and the cluster's A0..A3/B0..B3/cfg/en/rst pins.

Parameters:
- MIN_W, 8, operand lane width (matches `MAC_MIN_WIDTH`).
- ACC_W, 32, accumulator/output lane width (matches `MAC_ACC_WIDTH`).
- CONF_W, 4, cluster mode bits (matches `MAC_CONF_WIDTH`).
- LEN_W, 8, job beat-count width.
- DRAIN_CYC, 4, enabled cluster edges from the last-operand edge (inclusive) before outputs are sampled; must be ≥1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- job_valid, input, 1, job offer.
- job_ready, output, 1, job accept = (state==IDLE) & ~rst.
- job_cfg, input, 4*ACC_W+CONF_W, cluster cfg word (initial values plus mode bits).
- job_len, input, LEN_W, number of operand beats N.
- op_valid, input, 1, operand beat offer.
- op_ready, output, 1, = (state==RUN).
- op_a, input, 4*MIN_W, lanes A3..A0, A0 in the LSBs.
- op_b, input, 4*MIN_W, lanes B3..B0.
- clu_rst, output, 1, cluster reset (registered).
- clu_en, output, 1, cluster enable (registered).
- clu_cfg, output, 4*ACC_W+CONF_W, registered cfg to the cluster.
- clu_a, output, 4*MIN_W, registered operands to the cluster.
- clu_b, output, 4*MIN_W, registered operands to the cluster.
- clu_out, input, 4*ACC_W, cluster out3..out0.
- res_valid, output, 1, result valid.
- res_ready, input, 1, result accept.
- res_data, output, 4*ACC_W, snapshot of clu_out.
- busy, output, 1, = (state!=IDLE).

Behaviour:
- Reset values (async, while rst=1):
  - state=IDLE.
  - clu_rst=1; clu_en=0.
  - clu_a, clu_b, clu_cfg = 0.
  - res_valid=0; res_data=0; beat counter=0.
- First edge after reset release: clu_rst<=0.
- IDLE:
  - On job_valid&job_ready edge: clu_cfg<=job_cfg, cnt<=job_len, -> LOAD.
  - All other inputs are ignored.
- LOAD (exactly 1 cycle):
  - clu_rst is high for this cycle; clu_cfg is stable from here.
  - Exit: -> RUN if cnt!=0, else -> DRAIN. clu_rst<=0.
- RUN, per edge:
  - Beat = op_valid & op_ready.
  - On a beat: clu_en<=1, clu_a<=op_a, clu_b<=op_b, cnt<=cnt-1.
  - Without a beat: clu_en<=0, clu_a/clu_b hold.
  - The beat with cnt==1 moves to DRAIN.
- DRAIN (DRAIN_CYC cycles, internal counter):
  - Each edge drives clu_en<=1, clu_a<=0, clu_b<=0.
  - The cluster therefore sees the last operand plus DRAIN_CYC-1 zero-operand enabled edges. Zero products leave the accumulators unchanged.
  - On the final DRAIN edge: res_data<=clu_out, res_valid<=1, clu_en<=0, -> RESULT.
- RESULT:
  - res_valid and res_data are held stable until res_valid&res_ready; that edge sets res_valid<=0 and -> IDLE.
  - job_ready is 0 in RESULT; there is no job overlap.
- N=0: RUN is skipped; res_data equals the initial values loaded by clu_rst.
- Counter range: 1..2^LEN_W-1 beats; cnt never wraps because RUN exits at 1.
- clu_cfg is held from LOAD through RESULT and only changes on the next job accept.
- Reset mid-job (any state): async return to IDLE with reset values. Any pending result is discarded; no partial res_valid.
- Latency: job accept edge T -> clu_rst high in cycle T+1 -> op_ready from T+2. Last beat at edge E -> res_valid=1 after edge E+DRAIN_CYC.

Test Plan:
Bench uses a cluster stub: out_i loads cfg init_i on clu_rst; out_i += A_i*B_i on each clu_en edge, with 1-edge latency.

1. Basic run: init=0, N=3, lane0 A={1,2,3}, B={4,5,6}, other lanes A=B=1 -> res_data out0=32, out1..3=3.
   - Same job with init0=10 -> out0=42.
2. Operand stalls: op_valid pattern 1,0,0,1,0,1 with the beats of scenario 1 -> clu_en low during gaps, out0=32.
   - Result backpressure: res_ready low for 5 cycles -> res_valid and res_data stable throughout.
3. Zero length: N=0, inits {7,8,9,10} -> op_ready never high; res_data={10,9,8,7} (out3..out0); res_valid 1+DRAIN_CYC cycles after LOAD.
4. Reset mid-RUN: reset after 2 of 5 beats -> immediately state IDLE, clu_rst=1, clu_en=0, res_valid=0.
   - A following N=1 job with A0=B0=2, init 0 -> out0=4.
5. Timing check (DRAIN_CYC=4): accept at edge T -> clu_rst=1 exactly in cycle T+1, op_ready at T+2.
   - Last beat at edge E -> res_valid rises after edge E+4; clu_en=1 for the 4 cycles following edge E.
6. Maximum length (LEN_W=4): N=15, all lanes A=B=1, init 0 -> each out=15; exactly 15 op handshakes, none extra.
